uart_tx_arbiter: RTL and testbench

//  Shares the single USB-UART transmit channel (uart_in_data/valid/ready) between N byte sources
//  (rv32 core, debug monitor, ...). Packet-locked round-robin: a grantee keeps the channel until
//  end-of-line, a burst cap, or an idle timeout. One registered output stage feeds usb_uart_i40.

---
 rtl/uart_arb_pkg.sv | 29 ++
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Purpose: shared types and helpers for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

  typedef logic [7:0] byte_t;

  // Wide enough for up to 8 requesters.
  localparam int GRANT_W = 3;
  typedef logic [GRANT_W-1:0] gid_t;

  // Arbiter state: IDLE picks a grantee, LOCKED streams its packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Newline ends a text line and therefore a packet.
  localparam byte_t EOP_DEFAULT = 8'h0A;

  // Round-robin successor of a grantee index, wrapping to 0 after the last requester.
  function automatic gid_t next_ptr(input gid_t cur, input int n);
    if (int'(cur) >= n - 1) begin
      return '0;
    end
    return cur + gid_t'(1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles the requester byte ports and the single UART transmit channel.
// Latency: n/a (wiring only).
// Backpressure: req_ready/out_ready carry the valid-ready handshakes.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2
);

  // Requester side: one valid/ready pair and one byte lane per source.
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  // UART side: registered byte stream towards the transmitter.
  logic  out_valid;
  byte_t out_data;
  logic  out_ready;

  // Status.
  gid_t grant_id;
  logic busy;

  // Environment: byte sources plus the UART sink.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_id, busy
  );

  // Arbiter.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: round-robin picker, first set request at or after ptr (modulo N_REQ).
// Latency: combinational.
// Backpressure: none; found=0 when no request is set.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  gid_t             ptr,
  output gid_t             idx,
  output logic             found
);

  // Candidate index before wrap; one extra bit so ptr+k cannot overflow at N_REQ=8.
  logic [GRANT_W:0] cand;

  // Scan candidates ptr, ptr+1, ... and keep the first one that is requesting.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (GRANT_W + 1)'(k);
      if (cand >= (GRANT_W + 1)'(N_REQ)) begin
        cand = cand - (GRANT_W + 1)'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (cand == (GRANT_W + 1)'(j)) && req[j]) begin
          found = 1'b1;
          idx   = gid_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: packet-locked round-robin sharing of one UART transmit channel among N_REQ byte sources.
// Latency: accepted byte appears on out_data one cycle later; at least one dead cycle between grants.
// Backpressure: req_ready only to the grantee and only while the output register can load.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int    N_REQ        = 2,
  parameter byte_t EOP_BYTE     = EOP_DEFAULT,
  parameter int    MAX_BURST    = 64,
  parameter int    IDLE_TIMEOUT = 16
) (
  input logic         CLK,
  input logic         reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_T = 8'(IDLE_TIMEOUT);

  // Arbitration state.
  arb_state_t state, state_nxt;
  gid_t       grant_q, grant_nxt;
  gid_t       rr_ptr, rr_ptr_nxt;
  logic [7:0] burst_cnt, burst_nxt;
  logic [7:0] idle_cnt, idle_nxt;

  // Output register.
  logic  out_valid_q;
  byte_t out_data_q;

  // Grantee view and handshake terms.
  logic  gnt_valid;
  byte_t gnt_data;
  logic  load_ok;
  logic  xfer;
  logic  is_eop;
  logic  burst_last;
  logic  idle_last;

  // Picker result, only consulted in IDLE.
  gid_t pick_idx;
  logic pick_found;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Select the current grantee's valid and byte lane.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == gid_t'(i)) begin
        gnt_valid = bus.req_valid[i];
        gnt_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // The output register can take a byte when empty or draining this cycle.
  assign load_ok    = !out_valid_q || bus.out_ready;
  assign xfer       = (state == LOCKED) && gnt_valid && load_ok;
  assign is_eop     = (gnt_data == EOP_BYTE);
  assign burst_last = ((burst_cnt + 8'd1) == MAX_B);
  assign idle_last  = ((idle_cnt + 8'd1) == IDLE_T);

  // Ready goes only to the grantee; a stalled output register blocks it too.
  for (genvar g = 0; g < N_REQ; g++) begin : g_ready
    assign bus.req_ready[g] = (state == LOCKED) && (grant_q == gid_t'(g)) && load_ok;
  end

  // Next-state: grant in IDLE, count bytes/idle cycles in LOCKED, release on EOP, cap or timeout.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    rr_ptr_nxt = rr_ptr;
    burst_nxt  = burst_cnt;
    idle_nxt   = idle_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = LOCKED;
          grant_nxt = pick_idx;
          burst_nxt = '0;
          idle_nxt  = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          burst_nxt = burst_cnt + 8'd1;
          idle_nxt  = '0;
          if (is_eop || burst_last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = next_ptr(grant_q, N_REQ);
          end
        end else if (!gnt_valid) begin
          idle_nxt = idle_cnt + 8'd1;
          if (idle_last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = next_ptr(grant_q, N_REQ);
          end
        end
        // Grantee valid but output stalled: everything holds.
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbitration registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

  // Output register: load on transfer, clear on drain; reset discards any held byte.
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_data;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state == LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed test of uart_tx_arbiter with a scoreboard queue and independent monitors.
// Latency: expects each accepted byte on out_data one cycle after acceptance.
// Backpressure: bench drives out_ready and stalls the channel mid-packet.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(2)) bus ();

  logic  tb_valid [2];
  byte_t tb_data  [2];
  logic  tb_out_rdy;

  assign bus.req_valid = {tb_valid[1], tb_valid[0]};
  assign bus.req_data  = {tb_data[1], tb_data[0]};
  assign bus.out_ready = tb_out_rdy;

  uart_tx_arbiter #(
    .N_REQ        (2),
    .EOP_BYTE     (8'h0A),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (16)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    gid_t  id;
    byte_t dat;
  } exp_t;

  exp_t sb_q [$];
  int   pop_cyc [$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bytes: start, start+1, ... (n of them), then newline if eop.
  task automatic expect_seq(input int id, input int start, input int n, input bit eop);
    for (int k = 0; k < n; k++) sb_q.push_back({gid_t'(id), byte_t'(start + k)});
    if (eop) sb_q.push_back({gid_t'(id), 8'h0A});
  endtask

  task automatic send_byte(input int i, input byte_t b);
    int waited;
    waited = 0;
    tb_data[i]  = b;
    tb_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.req_ready[i] && waited < 200);
    if (!bus.req_ready[i]) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: requester %0d byte %0h never accepted", i, b);
    end
    @(posedge clk);
    #1;
  endtask

  // Requester i sends start..start+n-1 then optionally newline, back to back.
  task automatic send(input int i, input int start, input int n, input bit eop);
    for (int k = 0; k < n; k++) send_byte(i, byte_t'(start + k));
    if (eop) send_byte(i, 8'h0A);
    tb_valid[i] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb_q.size()), 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.busy), 0);
  endtask

  // Scoreboard monitor: every drained byte must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got byte %0h with nothing expected", bus.out_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", 32'(bus.out_data), 32'(e.dat));
          chk("sb_grant", 32'(bus.grant_id), 32'(e.id));
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Ready monitor: ready only ever reaches the locked grantee.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        logic [1:0] exp_rr;
        exp_rr = 2'b01 << bus.grant_id;
        chk("ready_grantee", 32'({bus.busy, bus.req_ready}), 32'({1'b1, exp_rr}));
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset       = 1'b1;
    tb_valid[0] = 1'b0;
    tb_valid[1] = 1'b0;
    tb_data[0]  = '0;
    tb_data[1]  = '0;
    tb_out_rdy  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // "hi\n" from requester 0, consecutive output bytes, release after newline.
    pop_cyc.delete();
    expect_seq(0, 'h68, 2, 1);
    send(0, 'h68, 2, 1);
    @(negedge clk);
    chk("t1_busy_after_eop", 32'(bus.busy), 0);
    chk("t1_grant_hold", 32'(bus.grant_id), 0);
    wait_drain("t1_drain");
    chk("t1_pop_count", 32'(pop_cyc.size()), 3);
    if (pop_cyc.size() >= 3) begin
      chk("t1_consec_a", 32'(pop_cyc[1] - pop_cyc[0]), 1);
      chk("t1_consec_b", 32'(pop_cyc[2] - pop_cyc[1]), 1);
    end

    // Both valid straight out of reset: req0 wins, then req1.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    expect_seq(0, 'h41, 1, 1);
    expect_seq(1, 'h42, 1, 1);
    fork
      send(0, 'h41, 1, 1);
      send(1, 'h42, 1, 1);
    join
    wait_drain("t2_drain");

    // Burst cap of 4: req0 10..13, req1 "B\n", req0 14..17 then 18,19, then timeout.
    expect_seq(0, 'h10, 4, 0);
    expect_seq(1, 'h42, 1, 1);
    expect_seq(0, 'h14, 6, 0);
    fork
      send(0, 'h10, 10, 0);
      send(1, 'h42, 1, 1);
    join
    wait_drain("t3_drain");
    wait_idle("t3_timeout_release");

    // Output stall of 5 cycles mid-packet.
    expect_seq(0, 'h31, 4, 1);
    fork
      send(0, 'h31, 4, 1);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(bus.out_valid && bus.out_data == 8'h32) && n < 100);
        @(posedge clk);
        #1 tb_out_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_valid", 32'(bus.out_valid), 1);
          chk("t4_stall_data", 32'(bus.out_data), 'h33);
          chk("t4_stall_ready", 32'(bus.req_ready), 0);
          chk("t4_stall_busy", 32'(bus.busy), 1);
        end
        @(posedge clk);
        #1 tb_out_rdy = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // One byte then silence: release after 16 idle cycles, waiting req1 granted next.
    expect_seq(0, 'h55, 1, 0);
    expect_seq(1, 'h66, 1, 1);
    send(0, 'h55, 1, 0);
    fork
      send(1, 'h66, 1, 1);
      begin
        repeat (15) @(negedge clk);
        @(negedge clk);
        chk("t5_busy_cycle16", 32'(bus.busy), 1);
        @(negedge clk);
        chk("t5_released", 32'(bus.busy), 0);
        chk("t5_grant_hold", 32'(bus.grant_id), 0);
        @(negedge clk);
        chk("t5_regrant_busy", 32'(bus.busy), 1);
        chk("t5_regrant_id", 32'(bus.grant_id), 1);
      end
    join
    wait_drain("t5_drain");
    wait_idle("t5_idle");

    // Reset while a byte sits in the output register; rr pointer must return to 0.
    expect_seq(0, 'h5A, 1, 1);
    send(0, 'h5A, 1, 1);
    wait_drain("t6_pre_drain");
    @(posedge clk);
    #1 tb_out_rdy = 1'b0;
    tb_data[1]  = 8'h77;
    tb_valid[1] = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.req_ready[1] && n < 50);
      chk("t6_req1_ready", 32'(bus.req_ready[1]), 1);
    end
    @(posedge clk);
    #1 tb_valid[1] = 1'b0;
    @(negedge clk);
    chk("t6_held_valid", 32'(bus.out_valid), 1);
    chk("t6_held_data", 32'(bus.out_data), 'h77);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_grant", 32'(bus.grant_id), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tb_out_rdy = 1'b1;
    expect_seq(0, 0, 0, 1);
    expect_seq(1, 0, 0, 1);
    fork
      send(0, 0, 0, 1);
      send(1, 0, 0, 1);
    join
    wait_drain("t6_drain");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
